// File: rtl/bram_queue_drain.sv
// bram_queue_drain: read side of the N_BRAM-lane BRAM ring-queue store.
//   Owns port B of every lane BRAM. A lane's tail word is a fresh entry when
//   its phase bit matches the lane's expected phase. Ready lanes are served
//   round-robin into a single valid/ack output slot.
// Ports:
//   CLK, RESET_N      clock, async active-low reset
//   writer_ready      writer finished its initialising pass over all lanes
//   addrb / qtail     per-lane tail pointers (port-B address / to writer)
//   doutb             per-lane port-B read data {phase, payload}, 1-cycle latency
//   dout_val/dout/dout_lane/dout_ack  output slot handshake
//   error             sticky sequence error (0 unless SEQ_CHECK_EN)
// Optional feature: define SEQ_CHECK_EN to enable per-lane sequence checking.
// DELAY is a simulation-only parameter kept for interface compatibility; the
// RTL applies no assignment delays.

module bram_queue_lane #(
  parameter int AW = 10,
  parameter int DW = 20
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [DW:0]   rd_word,
  input  logic          grant,
  input  logic          hold_stale,
  output logic [AW-1:0] tail,
  output logic          elig,
  output logic [DW-1:0] payload
);
  logic [AW-1:0] tail_q, tail_d;
  logic          phase_q, phase_d;
  logic          stale_q, stale_d;

  always_comb begin
    tail_d  = tail_q;
    phase_d = phase_q;
    // stale lasts exactly one cycle after a grant: the BRAM needs that edge
    // to sample the new tail address before its output is trustworthy.
    stale_d = hold_stale & stale_q;
    if (grant) begin
      tail_d  = tail_q + 1'b1;
      stale_d = 1'b1;
      if (&tail_q) phase_d = ~phase_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tail_q  <= '0;
      phase_q <= 1'b1;
      stale_q <= 1'b1;
    end else begin
      tail_q  <= tail_d;
      phase_q <= phase_d;
      stale_q <= stale_d;
    end
  end

  assign tail    = tail_q;
  assign elig    = (rd_word[DW] == phase_q) && !stale_q;
  assign payload = rd_word[DW-1:0];
endmodule

module bram_queue_drain #(
  parameter int DELAY          = 1,
  parameter int N_BRAM         = 8,
  parameter int BRAM_ADDR_SIZE = 10,
  parameter int BRAM_DATA_SIZE = 20
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   writer_ready,
  output logic [N_BRAM*BRAM_ADDR_SIZE-1:0]       addrb,
  input  logic [N_BRAM*(BRAM_DATA_SIZE+1)-1:0]   doutb,
  output logic [N_BRAM*BRAM_ADDR_SIZE-1:0]       qtail,
  output logic                                   dout_val,
  output logic [BRAM_DATA_SIZE-1:0]              dout,
  output logic [$clog2(N_BRAM)-1:0]              dout_lane,
  input  logic                                   dout_ack,
  output logic                                   error
);
  localparam int AW = BRAM_ADDR_SIZE;
  localparam int DW = BRAM_DATA_SIZE;
  localparam int LW = $clog2(N_BRAM);

`ifdef SEQ_CHECK_EN
  typedef enum logic [1:0] {S_INIT, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_INIT, S_RUN} state_t;
`endif

  state_t state_q, state_d;
  logic          dout_val_q, dout_val_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [LW-1:0] dout_lane_q, dout_lane_d;
  logic [LW-1:0] rr_q, rr_d;

  logic [N_BRAM-1:0][DW:0]   rd_word;
  logic [N_BRAM-1:0][AW-1:0] tail;
  logic [N_BRAM-1:0][DW-1:0] payload;
  logic [N_BRAM-1:0]         elig, grant;
  logic                      hold_stale, load, found, do_grant;
  logic [LW-1:0]             idx, gsel;

  assign rd_word = doutb;
  assign addrb   = tail;
  assign qtail   = tail;

  for (genvar i = 0; i < N_BRAM; i++) begin : g_lane
    bram_queue_lane #(.AW(AW), .DW(DW)) u_lane (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .rd_word   (rd_word[i]),
      .grant     (grant[i]),
      .hold_stale(hold_stale),
      .tail      (tail[i]),
      .elig      (elig[i]),
      .payload   (payload[i])
    );
  end

  // stale survives only while still waiting for the writer's init pass.
  assign hold_stale = (state_q == S_INIT) && !writer_ready;

  // Round-robin: search rr+1 .. rr+N_BRAM (wrapping), first eligible wins.
  always_comb begin
    load  = (state_q == S_RUN) && (!dout_val_q || dout_ack);
    found = 1'b0;
    gsel  = rr_q;
    idx   = '0;
    for (int k = 1; k <= N_BRAM; k++) begin
      idx = rr_q + LW'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
    do_grant = load && found;
    grant    = '0;
    if (do_grant) grant[gsel] = 1'b1;
  end

`ifdef SEQ_CHECK_EN
  logic                      error_q, error_d;
  logic [N_BRAM-1:0][DW-1:0] exp_q, exp_d;
`endif

  always_comb begin
    state_d     = state_q;
    dout_val_d  = dout_val_q;
    dout_d      = dout_q;
    dout_lane_d = dout_lane_q;
    rr_d        = rr_q;
`ifdef SEQ_CHECK_EN
    error_d     = error_q;
    exp_d       = exp_q;
`endif
    case (state_q)
      S_INIT: if (writer_ready) state_d = S_RUN;
      S_RUN: begin
        if (do_grant) begin
          dout_d      = payload[gsel];
          dout_lane_d = gsel;
          dout_val_d  = 1'b1;
          rr_d        = gsel;
`ifdef SEQ_CHECK_EN
          // The mismatching entry is still presented; only granting stops.
          if (payload[gsel] == exp_q[gsel]) exp_d[gsel] = exp_q[gsel] + 1'b1;
          else begin
            error_d = 1'b1;
            state_d = S_ERR;
          end
`endif
        end else if (load && dout_val_q) begin
          dout_val_d = 1'b0;
        end
      end
`ifdef SEQ_CHECK_EN
      S_ERR: if (dout_val_q && dout_ack) dout_val_d = 1'b0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_INIT;
      dout_val_q  <= 1'b0;
      dout_q      <= '0;
      dout_lane_q <= '0;
      rr_q        <= LW'(N_BRAM - 1);
    end else begin
      state_q     <= state_d;
      dout_val_q  <= dout_val_d;
      dout_q      <= dout_d;
      dout_lane_q <= dout_lane_d;
      rr_q        <= rr_d;
    end
  end

`ifdef SEQ_CHECK_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      error_q <= 1'b0;
      exp_q   <= '0;
    end else begin
      error_q <= error_d;
      exp_q   <= exp_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign dout_val  = dout_val_q;
  assign dout      = dout_q;
  assign dout_lane = dout_lane_q;
endmodule

// File: tb/tb_bram_queue_drain.sv
// Directed bench for bram_queue_drain with a behavioural lane-BRAM model
// (port-B registered read) and a writer model that tags each lap's phase.
module tb_bram_queue_drain;
  localparam int N  = 8;
  localparam int AW = 10;
  localparam int DW = 20;
  localparam int WW = DW + 1;
  localparam int DEPTH = 1 << AW;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              writer_ready = 1'b0;
  logic              dout_ack = 1'b0;
  logic [N*AW-1:0]   addrb, qtail;
  logic [N*WW-1:0]   doutb;
  logic              dout_val;
  logic [DW-1:0]     dout;
  logic [2:0]        dout_lane;
  logic              error;

  logic [WW-1:0] mem [N][DEPTH];
  logic [WW-1:0] rd_q [N];
  int            wptr [N];
  bit            wph [N];

  int errs = 0;
  int checks = 0;

  bram_queue_drain #(.DELAY(1), .N_BRAM(N), .BRAM_ADDR_SIZE(AW), .BRAM_DATA_SIZE(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .writer_ready(writer_ready),
    .addrb(addrb), .doutb(doutb), .qtail(qtail),
    .dout_val(dout_val), .dout(dout), .dout_lane(dout_lane),
    .dout_ack(dout_ack), .error(error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    for (int i = 0; i < N; i++) rd_q[i] <= mem[i][addrb[i*AW +: AW]];

  for (genvar g = 0; g < N; g++) begin : g_rd
    assign doutb[g*WW +: WW] = rd_q[g];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic clr_mem;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
      wptr[i] = 0;
      wph[i]  = 1'b1;
    end
  endtask

  task automatic push(input int l, input int v);
    logic [DW-1:0] pv;
    pv = v[DW-1:0];
    mem[l][wptr[l]] = {wph[l], pv};
    wptr[l] = (wptr[l] + 1) % DEPTH;
    if (wptr[l] == 0) wph[l] = ~wph[l];
  endtask

  // Reset, clear the store, release; leaves the DUT in RUN (writer_ready=1).
  task automatic do_reset;
    RESET_N  = 1'b0;
    dout_ack = 1'b0;
    clr_mem();
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic wait_val(input string tag);
    int n;
    n = 0;
    tick();
    while (!dout_val && n < 8) begin
      tick();
      n++;
    end
    chk(tag, dout_val, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int nbad;
    logic [AW-1:0]   q1023, q1024;
    logic [N*AW-1:0] q_ones, q_snap;

    clr_mem();
    tick();
    // reset state
    chk("rst_val", dout_val, 0);
    chk("rst_dout", dout, 0);
    chk("rst_lane", dout_lane, 0);
    chk("rst_err", error, 0);
    chk("rst_qtail", qtail, 0);
    chk("rst_addrb", addrb, 0);

    // held in INIT until writer_ready
    RESET_N = 1'b1;
    push(2, 7);
    seen = 0;
    repeat (20) begin
      tick();
      if (dout_val) seen++;
    end
    chk("init_hold", seen, 0);
    writer_ready = 1'b1;
    tick();
    chk("init_edge_val", dout_val, 0);
    tick();
    chk("init_val", dout_val, 1);
    chk("init_dout", dout, 7);
    chk("init_lane", dout_lane, 2);
    dout_ack = 1'b1;
    tick();
    chk("ack_empty", dout_val, 0);
    chk("tail2", qtail[2*AW +: AW], 1);

    // write-to-output latency, lane 3
    push(3, 5);
    tick();
    chk("lat_w1", dout_val, 0);
    tick();
    chk("lat_val", dout_val, 1);
    chk("lat_dout", dout, 5);
    chk("lat_lane", dout_lane, 3);
    chk("lat_tail3", qtail[3*AW +: AW], 1);
    tick();
    chk("lat_drain", dout_val, 0);

    // all lanes at once: round-robin from lane 0, one per cycle
    do_reset();
    dout_ack = 1'b1;
    for (int l = 0; l < N; l++) push(l, 16 + l);
    tick();
    chk("rr_bram", dout_val, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      chk("rr_val", dout_val, 1);
      chk("rr_lane", dout_lane, k);
      chk("rr_dout", dout, 16 + k);
    end
    tick();
    chk("rr_drain", dout_val, 0);
    for (int i = 0; i < N; i++) q_ones[i*AW +: AW] = 1;
    chk("rr_qtail", qtail, q_ones);

    // lane 0 wraps: 1025 entries
    do_reset();
    dout_ack = 1'b1;
    nbad = 0;
    q1023 = '1;
    q1024 = '0;
    for (int v = 0; v <= DEPTH; v++) begin
      push(0, v);
      wait_val("wrap_to");
      if (dout !== v[DW-1:0] || dout_lane !== 3'd0) nbad++;
      if (v == DEPTH - 1) q1023 = qtail[AW-1:0];
      if (v == DEPTH)     q1024 = qtail[AW-1:0];
    end
    chk("wrap_data", nbad, 0);
    chk("wrap_tail1023", q1023, 0);
    chk("wrap_tail1024", q1024, 1);
    tick();
    seen = 0;
    repeat (6) begin
      tick();
      if (dout_val) seen++;
    end
    chk("wrap_stale", seen, 0);

    // backpressure hold, then asynchronous reset mid-hold
    do_reset();
    push(4, 9);
    wait_val("bp_to");
    chk("bp_first", dout, 9);
    q_snap = qtail;
    for (int c = 0; c < 10; c++) begin
      push(4 + (c % 4), 100 + c);
      tick();
      chk("bp_val", dout_val, 1);
      chk("bp_dout", dout, 9);
      chk("bp_lane", dout_lane, 4);
      chk("bp_qtail", qtail, q_snap);
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_val", dout_val, 0);
    chk("async_rst_qtail", qtail, 0);
    tick();

`ifdef SEQ_CHECK_EN
    // sequence check: 0,1,3 on lane 1
    do_reset();
    dout_ack = 1'b1;
    push(1, 0);
    push(1, 1);
    push(1, 3);
    wait_val("seq_to0");
    chk("seq_d0", dout, 0);
    chk("seq_e0", error, 0);
    wait_val("seq_to1");
    chk("seq_d1", dout, 1);
    chk("seq_e1", error, 0);
    wait_val("seq_to3");
    chk("seq_d3", dout, 3);
    chk("seq_e3", error, 1);
    push(1, 4);
    tick();
    seen = 0;
    repeat (6) begin
      tick();
      if (dout_val) seen++;
    end
    chk("seq_stop", seen, 0);
    chk("seq_sticky", error, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
